// File: rtl/wrap_history_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// wrap_pkg
// Shared definitions for the wrap history scheduler:
//   state_t     - scheduler phase: WRAP (halo rows replayed) or DATA (pass-through)
//   clog2_min1  - $clog2 clamped to at least one bit, for counter/index widths
// -----------------------------------------------------------------------------
package wrap_pkg;

   typedef enum logic {
      WRAP = 1'b0,
      DATA = 1'b1
   } state_t;

   // Width needed to count 0..v-1, never less than one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/wrap_history_buf.sv
// -----------------------------------------------------------------------------
// wrap_history_buf
// Register-array store holding the last WRAP_Y rows of the previous frame.
// One synchronous write port, one combinational read port. Contents are not
// reset; the owner qualifies their use with its own "primed" flag.
//
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_row   in   history row to write (0..WRAP_Y-1)
//   wr_col   in   beat column to write (0..ITER_X-1)
//   wr_data  in   one beat, UNROLL_IN_X elements of IN_WIDTH bits
//   rd_row   in   history row to read
//   rd_col   in   beat column to read
//   rd_data  out  beat at (rd_row, rd_col), combinational
// -----------------------------------------------------------------------------
module wrap_history_buf
   import wrap_pkg::*;
#(
   parameter int WRAP_Y      = 1,
   parameter int ITER_X      = 2,
   parameter int UNROLL_IN_X = 5,
   parameter int IN_WIDTH    = 32
) (
   input  logic                                  clk,
   input  logic                                  wr_en,
   input  logic [clog2_min1(WRAP_Y)-1:0]         wr_row,
   input  logic [clog2_min1(ITER_X)-1:0]         wr_col,
   input  logic [UNROLL_IN_X*IN_WIDTH-1:0]       wr_data,
   input  logic [clog2_min1(WRAP_Y)-1:0]         rd_row,
   input  logic [clog2_min1(ITER_X)-1:0]         rd_col,
   output logic [UNROLL_IN_X*IN_WIDTH-1:0]       rd_data
);

   localparam int BEAT_W = UNROLL_IN_X * IN_WIDTH;
   localparam int DEPTH  = WRAP_Y * ITER_X;
   localparam int IDX_W  = clog2_min1(DEPTH);

   logic [BEAT_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   // Row-major flattening: entry = row * ITER_X + col.
   assign wr_idx = IDX_W'(int'(wr_row) * ITER_X + int'(wr_col));
   assign rd_idx = IDX_W'(int'(rd_row) * ITER_X + int'(rd_col));

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/wrap_history_scheduler.sv
// -----------------------------------------------------------------------------
// wrap_history_scheduler
// Feeds wrap_data: each frame starts with WRAP_Y halo rows replayed from the
// tail of the previous frame (or PAD_VALUE when no history is held), followed
// by IN_Y data rows passed straight through. The last WRAP_Y data rows of a
// frame are captured for replay as the next frame's halo.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   clear                          one-cycle pulse: discard history
//   data_in / _valid / _ready      upstream frame beats
//   data_out / _valid / _ready     to wrap_data data port (pass-through)
//   wrap_out / _valid / _ready     to wrap_data wrap port (halo beats)
//   primed                         history holds a complete previous frame tail
// -----------------------------------------------------------------------------
module wrap_history_scheduler
   import wrap_pkg::*;
#(
   parameter int                IN_WIDTH    = 32,
   parameter int                WRAP_Y      = 1,
   parameter int                IN_Y        = 2,
   parameter int                IN_X        = 10,
   parameter int                UNROLL_IN_X = 5,
   parameter logic [IN_WIDTH-1:0] PAD_VALUE = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clear,
   input  logic [UNROLL_IN_X*IN_WIDTH-1:0]   data_in,
   input  logic                              data_in_valid,
   output logic                              data_in_ready,
   output logic [UNROLL_IN_X*IN_WIDTH-1:0]   data_out,
   output logic                              data_out_valid,
   input  logic                              data_out_ready,
   output logic [UNROLL_IN_X*IN_WIDTH-1:0]   wrap_out,
   output logic                              wrap_out_valid,
   input  logic                              wrap_out_ready,
   output logic                              primed
);

   localparam int ITER_X = IN_X / UNROLL_IN_X;
   localparam int BEAT_W = UNROLL_IN_X * IN_WIDTH;
   localparam int XW     = clog2_min1(ITER_X);
   localparam int YW     = clog2_min1((WRAP_Y > IN_Y) ? WRAP_Y : IN_Y);
   localparam int ROW_W  = clog2_min1(WRAP_Y);
   localparam int TAIL_Y = IN_Y - WRAP_Y;

   localparam logic [BEAT_W-1:0] PAD_BEAT = {UNROLL_IN_X{PAD_VALUE}};

   state_t          state, state_d;
   logic [XW-1:0]   x, x_d;
   logic [YW-1:0]   y, y_d;
   logic            primed_d;
   logic            clear_pend, clear_pend_d;

   logic            wrap_fire;
   logic            data_fire;
   logic            last_x;
   logic            frame_end;

   logic            hist_wr_en;
   logic [ROW_W-1:0] hist_wr_row;
   logic [BEAT_W-1:0] hist_rd_data;

   assign last_x    = (x == XW'(ITER_X - 1));
   assign wrap_fire = (state == WRAP) && wrap_out_ready;
   assign data_fire = (state == DATA) && data_in_valid && data_out_ready;

   // Capture the tail rows of the frame; the write lands on the same edge as
   // the handshake, and is only read back after the move into WRAP.
   assign hist_wr_en  = data_fire && (int'(y) >= TAIL_Y);
   assign hist_wr_row = ROW_W'(int'(y) - TAIL_Y);

   wrap_history_buf #(
      .WRAP_Y      (WRAP_Y),
      .ITER_X      (ITER_X),
      .UNROLL_IN_X (UNROLL_IN_X),
      .IN_WIDTH    (IN_WIDTH)
   ) u_hist (
      .clk     (clk),
      .wr_en   (hist_wr_en),
      .wr_row  (hist_wr_row),
      .wr_col  (x),
      .wr_data (data_in),
      .rd_row  (ROW_W'(y)),
      .rd_col  (x),
      .rd_data (hist_rd_data)
   );

   // State, counters and history flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WRAP;
         x          <= '0;
         y          <= '0;
         primed     <= 1'b0;
         clear_pend <= 1'b0;
      end else begin
         state      <= state_d;
         x          <= x_d;
         y          <= y_d;
         primed     <= primed_d;
         clear_pend <= clear_pend_d;
      end
   end

   // Outputs: valids depend only on state and upstream valid, never on ready.
   always_comb begin
      data_out       = data_in;
      data_out_valid = 1'b0;
      data_in_ready  = 1'b0;
      wrap_out_valid = 1'b0;
      wrap_out       = primed ? hist_rd_data : PAD_BEAT;
      if (state == DATA) begin
         data_out_valid = data_in_valid;
         data_in_ready  = data_out_ready;
      end else begin
         wrap_out_valid = 1'b1;
      end
   end

   // Next-state, counter and clear handling
   always_comb begin
      state_d      = state;
      x_d          = x;
      y_d          = y;
      primed_d     = primed;
      clear_pend_d = clear_pend;
      frame_end    = 1'b0;

      case (state)
         WRAP: begin
            if (wrap_fire) begin
               if (last_x) begin
                  x_d = '0;
                  if (y == YW'(WRAP_Y - 1)) begin
                     y_d     = '0;
                     state_d = DATA;
                  end else begin
                     y_d = y + 1'b1;
                  end
               end else begin
                  x_d = x + 1'b1;
               end
            end
         end
         DATA: begin
            if (data_fire) begin
               if (last_x) begin
                  x_d = '0;
                  if (y == YW'(IN_Y - 1)) begin
                     y_d       = '0;
                     state_d   = WRAP;
                     frame_end = 1'b1;
                  end else begin
                     y_d = y + 1'b1;
                  end
               end else begin
                  x_d = x + 1'b1;
               end
            end
         end
         default: begin
            state_d = WRAP;
            x_d     = '0;
            y_d     = '0;
         end
      endcase

      // A clear never disturbs a frame already in flight: it is deferred to
      // the frame boundary, except at the very start of WRAP before any halo
      // beat has been handed out, where dropping history is invisible.
      if (frame_end) begin
         primed_d     = !(clear_pend || clear);
         clear_pend_d = 1'b0;
      end else if (clear) begin
         if ((state == WRAP) && (x == '0) && (y == '0) && !wrap_fire) begin
            primed_d = 1'b0;
         end else begin
            clear_pend_d = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wrap_history_scheduler.sv
module tb_wrap_history_scheduler;

   localparam int BW = 160;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic [BW-1:0] data_in = '0;
   logic          data_in_valid = 1'b0;
   logic          data_in_ready;
   logic [BW-1:0] data_out;
   logic          data_out_valid;
   logic          data_out_ready = 1'b0;
   logic [BW-1:0] wrap_out;
   logic          wrap_out_valid;
   logic          wrap_out_ready = 1'b0;
   logic          primed;

   logic          rst_b = 1'b1;
   logic          clear_b = 1'b0;
   logic [BW-1:0] data_in_b = '0;
   logic          data_in_valid_b = 1'b0;
   logic          data_in_ready_b;
   logic [BW-1:0] data_out_b;
   logic          data_out_valid_b;
   logic          data_out_ready_b = 1'b0;
   logic [BW-1:0] wrap_out_b;
   logic          wrap_out_valid_b;
   logic          wrap_out_ready_b = 1'b0;
   logic          primed_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wrap_history_scheduler dut (
      .clk(clk), .rst(rst), .clear(clear),
      .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
      .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
      .wrap_out(wrap_out), .wrap_out_valid(wrap_out_valid), .wrap_out_ready(wrap_out_ready),
      .primed(primed)
   );

   wrap_history_scheduler #(.WRAP_Y(2), .IN_Y(3)) dut_b (
      .clk(clk), .rst(rst_b), .clear(clear_b),
      .data_in(data_in_b), .data_in_valid(data_in_valid_b), .data_in_ready(data_in_ready_b),
      .data_out(data_out_b), .data_out_valid(data_out_valid_b), .data_out_ready(data_out_ready_b),
      .wrap_out(wrap_out_b), .wrap_out_valid(wrap_out_valid_b), .wrap_out_ready(wrap_out_ready_b),
      .primed(primed_b)
   );

   function automatic logic [BW-1:0] rep(input int v);
      logic [31:0] e;
      e = v[31:0];
      return {5{e}};
   endfunction

   // Stimulus helpers: take one beat, bounded wait on the handshake.
   task automatic wrap_beat(output logic [BW-1:0] w);
      int n = 0;
      while (!wrap_out_valid && n < 20) begin @(posedge clk); #1; n++; end
      tests++;
      if (wrap_out_valid !== 1'b1) begin
         fails++; $display("FAIL wrap_beat_timeout got=%b want=1", wrap_out_valid);
      end
      wrap_out_ready = 1'b1; #1;
      w = wrap_out;
      @(posedge clk); #1;
      wrap_out_ready = 1'b0;
   endtask

   task automatic data_beat(input int v, output logic [BW-1:0] o);
      int n = 0;
      data_in = rep(v); data_in_valid = 1'b1; data_out_ready = 1'b1; #1;
      while (!data_in_ready && n < 20) begin @(posedge clk); #1; n++; end
      tests++;
      if (data_in_ready !== 1'b1) begin
         fails++; $display("FAIL data_beat_timeout got=%b want=1", data_in_ready);
      end
      o = data_out;
      @(posedge clk); #1;
      data_in_valid = 1'b0; data_out_ready = 1'b0;
   endtask

   task automatic wrap_beat_b(output logic [BW-1:0] w);
      int n = 0;
      while (!wrap_out_valid_b && n < 20) begin @(posedge clk); #1; n++; end
      tests++;
      if (wrap_out_valid_b !== 1'b1) begin
         fails++; $display("FAIL wrap_beat_b_timeout got=%b want=1", wrap_out_valid_b);
      end
      wrap_out_ready_b = 1'b1; #1;
      w = wrap_out_b;
      @(posedge clk); #1;
      wrap_out_ready_b = 1'b0;
   endtask

   task automatic data_beat_b(input int v, output logic [BW-1:0] o);
      int n = 0;
      data_in_b = rep(v); data_in_valid_b = 1'b1; data_out_ready_b = 1'b1; #1;
      while (!data_in_ready_b && n < 20) begin @(posedge clk); #1; n++; end
      tests++;
      if (data_in_ready_b !== 1'b1) begin
         fails++; $display("FAIL data_beat_b_timeout got=%b want=1", data_in_ready_b);
      end
      o = data_out_b;
      @(posedge clk); #1;
      data_in_valid_b = 1'b0; data_out_ready_b = 1'b0;
   endtask

   task automatic test_reset();
      logic [BW-1:0] w, o;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; #1;
      tests++;
      if ({wrap_out_valid, data_out_valid, data_in_ready, primed} !== 4'b1000) begin
         fails++; $display("FAIL reset_flags got=%b want=1000",
                           {wrap_out_valid, data_out_valid, data_in_ready, primed});
      end
      tests++;
      if (wrap_out !== '0) begin fails++; $display("FAIL reset_wrap_out got=%h want=0", wrap_out); end
      for (int i = 0; i < 2; i++) begin
         wrap_beat(w);
         tests++;
         if (w !== '0) begin fails++; $display("FAIL first_wrap%0d got=%h want=0", i, w); end
      end
      for (int v = 1; v <= 4; v++) begin
         data_beat(v, o);
         tests++;
         if (o !== rep(v)) begin fails++; $display("FAIL first_data%0d got=%h want=%h", v, o, rep(v)); end
         tests++;
         if (primed !== (v == 4)) begin
            fails++; $display("FAIL first_primed%0d got=%b want=%b", v, primed, (v == 4));
         end
      end
   endtask

   task automatic test_replay();
      logic [BW-1:0] w, o;
      for (int i = 0; i < 2; i++) begin
         wrap_beat(w);
         tests++;
         if (w !== rep(3 + i)) begin fails++; $display("FAIL replay_wrap%0d got=%h want=%h", i, w, rep(3 + i)); end
      end
      for (int v = 5; v <= 8; v++) begin
         data_beat(v, o);
         tests++;
         if (o !== rep(v)) begin fails++; $display("FAIL replay_data%0d got=%h want=%h", v, o, rep(v)); end
      end
   endtask

   task automatic test_backpressure();
      logic [BW-1:0] w;
      int n;
      logic took;
      wrap_beat(w);
      tests++;
      if (w !== rep(7)) begin fails++; $display("FAIL bp_wrap0 got=%h want=%h", w, rep(7)); end
      data_in = rep(99); data_in_valid = 1'b1; data_out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         tests++;
         if (wrap_out !== rep(8) || wrap_out_valid !== 1'b1) begin
            fails++; $display("FAIL bp_stall%0d got=%h/%b want=%h/1", c, wrap_out, wrap_out_valid, rep(8));
         end
         tests++;
         if (data_in_ready !== 1'b0 || data_out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_wrap_ready%0d got=%b%b want=00", c, data_in_ready, data_out_valid);
         end
         @(posedge clk); #1;
      end
      data_in_valid = 1'b0; data_out_ready = 1'b0;
      wrap_beat(w);
      tests++;
      if (w !== rep(8)) begin fails++; $display("FAIL bp_wrap1 got=%h want=%h", w, rep(8)); end
      for (int v = 9; v <= 12; v++) begin
         data_in = rep(v); data_in_valid = 1'b1;
         n = 0; took = 1'b0;
         while (!took && n < 50) begin
            data_out_ready = 1'($urandom_range(0, 1));
            #1;
            tests++;
            if (data_out !== rep(v) || data_out_valid !== 1'b1 || data_in_ready !== data_out_ready) begin
               fails++; $display("FAIL bp_data%0d got=%h/%b/%b want=%h/1/%b", v, data_out,
                                 data_out_valid, data_in_ready, rep(v), data_out_ready);
            end
            took = data_out_ready;
            @(posedge clk); #1;
            n++;
         end
         tests++;
         if (!took) begin fails++; $display("FAIL bp_data_timeout%0d got=0 want=1", v); end
      end
      data_in_valid = 1'b0; data_out_ready = 1'b0;
   endtask

   task automatic test_clear();
      logic [BW-1:0] w, o;
      for (int i = 0; i < 2; i++) begin
         wrap_beat(w);
         tests++;
         if (w !== rep(11 + i)) begin fails++; $display("FAIL clr_wrap%0d got=%h want=%h", i, w, rep(11 + i)); end
      end
      for (int v = 13; v <= 16; v++) begin
         data_beat(v, o);
         tests++;
         if (o !== rep(v)) begin fails++; $display("FAIL clr_data%0d got=%h want=%h", v, o, rep(v)); end
         if (v == 13) begin
            clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
         end
      end
      tests++;
      if (primed !== 1'b0) begin fails++; $display("FAIL clr_primed_end got=%b want=0", primed); end
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (primed !== 1'b0) begin fails++; $display("FAIL clr_primed_wrap%0d got=%b want=0", i, primed); end
         wrap_beat(w);
         tests++;
         if (w !== '0) begin fails++; $display("FAIL clr_pad%0d got=%h want=0", i, w); end
      end
      for (int v = 17; v <= 20; v++) data_beat(v, o);
      tests++;
      if (primed !== 1'b1) begin fails++; $display("FAIL clr_reprimed got=%b want=1", primed); end
   endtask

   task automatic test_reset_mid_data();
      logic [BW-1:0] w, o;
      for (int i = 0; i < 2; i++) begin
         wrap_beat(w);
         tests++;
         if (w !== rep(19 + i)) begin fails++; $display("FAIL rmd_wrap%0d got=%h want=%h", i, w, rep(19 + i)); end
      end
      data_beat(21, o);
      data_in = rep(22); data_in_valid = 1'b1; data_out_ready = 1'b1;
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0; #1;
      tests++;
      if ({wrap_out_valid, primed, data_out_valid, data_in_ready} !== 4'b1000) begin
         fails++; $display("FAIL rmd_flags got=%b want=1000",
                           {wrap_out_valid, primed, data_out_valid, data_in_ready});
      end
      data_in_valid = 1'b0; data_out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wrap_beat(w);
         tests++;
         if (w !== '0) begin fails++; $display("FAIL rmd_pad%0d got=%h want=0", i, w); end
      end
   endtask

   task automatic test_alt_params();
      logic [BW-1:0] w, o;
      rst_b = 1'b1; @(posedge clk); #1; rst_b = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         wrap_beat_b(w);
         tests++;
         if (w !== '0) begin fails++; $display("FAIL alt_pad%0d got=%h want=0", i, w); end
      end
      for (int v = 1; v <= 6; v++) begin
         data_beat_b(v, o);
         tests++;
         if (o !== rep(v)) begin fails++; $display("FAIL alt_data%0d got=%h want=%h", v, o, rep(v)); end
      end
      tests++;
      if (primed_b !== 1'b1) begin fails++; $display("FAIL alt_primed got=%b want=1", primed_b); end
      for (int i = 0; i < 4; i++) begin
         wrap_beat_b(w);
         tests++;
         if (w !== rep(3 + i)) begin fails++; $display("FAIL alt_wrap%0d got=%h want=%h", i, w, rep(3 + i)); end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_replay();
      test_backpressure();
      test_clear();
      test_reset_mid_data();
      test_alt_params();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
